ctrl_datapath: RTL

Datapath that consumes the 16-bit control word from the lab's FSM controller and carries out the loads, multiply, ALU and accumulate operations it encodes. One control word is applied per cycle; the block returns a result through a valid/ready handshake. It also flags protocol overruns and counts busy cycles.

---
 rtl/ctrl_datapath_if.sv | 29 ++
 rtl/ctrl_datapath.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/ctrl_datapath_if.sv
// ctrl_datapath_if: bundles the control word, operand inputs and the result
// handshake/status of ctrl_datapath. The master drives control, operands and
// out_ready; the slave (the datapath) drives result and the status outputs.
interface ctrl_datapath_if #(
  parameter int WIDTH = 9
);

  logic [15:0]        control;
  logic [WIDTH-1:0]   in_a;
  logic [WIDTH-1:0]   in_b;
  logic [WIDTH-1:0]   in_c;
  logic [2*WIDTH-1:0] result;
  logic               out_valid;
  logic               out_ready;
  logic               overrun;
  logic               busy;
  logic [3:0]         cycle_cnt;

  modport master (
    output control, in_a, in_b, in_c, out_ready,
    input  result, out_valid, overrun, busy, cycle_cnt
  );

  modport slave (
    input  control, in_a, in_b, in_c, out_ready,
    output result, out_valid, overrun, busy, cycle_cnt
  );

endinterface

// File: rtl/ctrl_datapath.sv
// ctrl_datapath: executes one 16-bit control word per cycle (operand loads,
// signed/unsigned multiply, ALU, accumulate) and returns the accumulator
// through a valid/ready result port. Also flags result overruns and counts
// busy cycles.
// Optional feature: define ACC_SAT_EN to make the accumulate saturate at
// 2^(2*WIDTH)-1 instead of wrapping.
module ctrl_datapath #(
  parameter int WIDTH = 9
) (
  input  logic           clk,
  input  logic           rst_n,
  ctrl_datapath_if.slave bus
);

  localparam int W2 = 2 * WIDTH;

  // Control word fields
  logic       w_ldA, w_ldB, w_ldC, w_enT1, w_enT2;
  logic       w_mulSel, w_addASel, w_addBSel;
  logic       w_enAcc, w_clrAcc, w_done, w_sgn, w_shr;
  logic [1:0] w_aluOp;
  logic       w_load;
  logic       w_unused;

  assign w_ldA     = bus.control[15];
  assign w_ldB     = bus.control[14];
  assign w_ldC     = bus.control[13];
  assign w_enT1    = bus.control[12];
  assign w_enT2    = bus.control[11];
  assign w_mulSel  = bus.control[10];
  assign w_addASel = bus.control[9];
  assign w_addBSel = bus.control[8];
  assign w_enAcc   = bus.control[7];
  assign w_clrAcc  = bus.control[6];
  assign w_done    = bus.control[5];
  assign w_aluOp   = bus.control[4:3];
  assign w_sgn     = bus.control[2];
  assign w_shr     = bus.control[1];
  assign w_unused  = bus.control[0];
  assign w_load    = w_ldA | w_ldB | w_ldC;

  // Datapath registers
  logic [WIDTH-1:0] r_ra, r_rb, r_rc;
  logic [W2-1:0]    r_t1, r_t2, r_acc, r_result;
  logic             r_outValid, r_overrun, r_busy;
  logic [3:0]       r_cycleCnt;

  // Combinational operands (all built from pre-edge register values)
  logic [WIDTH-1:0]     w_mulOp;
  logic signed [W2-1:0] w_mulAs, w_mulBs, w_mulS;
  logic [W2-1:0]        w_mulU, w_mul;
  logic [W2-1:0]        w_aluA, w_aluB, w_alu, w_t2Next;
  logic [W2:0]          w_accSum;
  logic [W2-1:0]        w_accNext;
  logic                 w_handshake;

  assign w_mulOp = w_mulSel ? r_t2[WIDTH-1:0] : r_rb;
  assign w_mulAs = $signed({{WIDTH{r_ra[WIDTH-1]}}, r_ra});
  assign w_mulBs = $signed({{WIDTH{w_mulOp[WIDTH-1]}}, w_mulOp});
  assign w_mulS  = w_mulAs * w_mulBs;
  assign w_mulU  = {{WIDTH{1'b0}}, r_ra} * {{WIDTH{1'b0}}, w_mulOp};
  assign w_mul   = w_sgn ? $unsigned(w_mulS) : w_mulU;

  assign w_aluA = w_addASel ? r_t2 : r_t1;
  assign w_aluB = w_addBSel ? r_t1 : {{WIDTH{1'b0}}, r_rc};

  // ALU operation select; all arithmetic wraps at 2*WIDTH bits
  always_comb begin
    w_alu = w_aluA;
    case (w_aluOp)
      2'b00:   w_alu = w_aluA + w_aluB;
      2'b01:   w_alu = w_aluA - w_aluB;
      2'b10:   w_alu = w_aluA & w_aluB;
      default: w_alu = w_aluA;
    endcase
  end

  assign w_t2Next = w_shr ? (w_alu >> 1) : w_alu;

  assign w_accSum = {1'b0, r_acc} + {1'b0, r_t2};
`ifdef ACC_SAT_EN
  assign w_accNext = w_accSum[W2] ? {W2{1'b1}} : w_accSum[W2-1:0];
`else
  assign w_accNext = w_accSum[W2-1:0];
`endif

  assign w_handshake = r_outValid & bus.out_ready;

  // Operand and temporary registers, each gated by its own enable bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ra <= '0;
      r_rb <= '0;
      r_rc <= '0;
      r_t1 <= '0;
      r_t2 <= '0;
    end else begin
      if (w_ldA)  r_ra <= bus.in_a;
      if (w_ldB)  r_rb <= bus.in_b;
      if (w_ldC)  r_rc <= bus.in_c;
      if (w_enT1) r_t1 <= w_mul;
      if (w_enT2) r_t2 <= w_t2Next;
    end
  end

  // Accumulator: clear beats accumulate
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (w_clrAcc) begin
      r_acc <= '0;
    end else if (w_enAcc) begin
      r_acc <= w_accNext;
    end
  end

  // Result port: capture on done when the slot is free (or freed this edge),
  // otherwise drop the new value and latch a sticky overrun
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result   <= '0;
      r_outValid <= 1'b0;
      r_overrun  <= 1'b0;
    end else if (w_done && (!r_outValid || w_handshake)) begin
      r_result   <= r_acc;
      r_outValid <= 1'b1;
    end else if (w_done) begin
      r_overrun  <= 1'b1;
    end else if (w_handshake) begin
      r_outValid <= 1'b0;
    end
  end

  // Busy flag and saturating busy-cycle counter; done wins over a load for
  // busy, while a load always restarts the counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy     <= 1'b0;
      r_cycleCnt <= '0;
    end else begin
      if (w_done)      r_busy <= 1'b0;
      else if (w_load) r_busy <= 1'b1;

      if (w_load)                           r_cycleCnt <= '0;
      else if (r_busy && r_cycleCnt != 4'd15) r_cycleCnt <= r_cycleCnt + 4'd1;
    end
  end

  assign bus.result    = r_result;
  assign bus.out_valid = r_outValid;
  assign bus.overrun   = r_overrun;
  assign bus.busy      = r_busy;
  assign bus.cycle_cnt = r_cycleCnt;

endmodule
